// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared state encoding and byte width for the UART receive  |
// | controller.                                                           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_BREAK = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_fifo : byte FIFO with separate occupancy count and            |
// | drop-on-full. A push into a full FIFO is accepted only with a pop.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [BYTE_W-1:0] rd_data,
    output logic [CW-1:0]     count,
    output logic              pushed,
    output logic              popped,
    output logic              dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_empty;
    logic w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign popped  = rd_req & ~w_empty;
    assign pushed  = wr_en & (~w_full | popped);
    assign dropped = wr_en & w_full & ~popped;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (pushed) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (popped) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (pushed && !popped) begin
                r_count <= r_count + CW'(1);
            end else if (popped && !pushed) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign rd_valid = ~w_empty;
    assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_ctrl : receive-enable flow control, BREAK handling, sticky    |
// | overrun/break flags and idle timeout in front of a byte FIFO.         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int BREAK_GAP    = 256,
    parameter int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ctrl_en,
    input  logic              clr_status,
    input  logic              rx_valid,
    input  logic              rx_break,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_en,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [BYTE_W-1:0] rd_data,
    output logic [CW-1:0]     fifo_count,
    output logic              overrun,
    output logic              break_det,
    output logic              idle_irq
);

    localparam logic [15:0] c_gap_load  = 16'(BREAK_GAP - 1);
    localparam logic [15:0] c_idle_trip = 16'(IDLE_TIMEOUT);

    rx_state_t   r_state;
    logic [15:0] r_gap;
    logic [15:0] r_idle;
    logic        r_idle_irq;
    logic        r_overrun;
    logic        r_break_det;

    logic        w_brk;
    logic        w_wr;
    logic        w_pushed;
    logic        w_popped;
    logic        w_dropped;
    logic        w_idle_clr;
    logic [15:0] w_idle_next;

    assign w_brk = rx_valid & rx_break & (rx_data == '0);
    assign w_wr  = rx_valid & ~w_brk;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (w_wr),
        .wr_data  (rx_data),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (fifo_count),
        .pushed   (w_pushed),
        .popped   (w_popped),
        .dropped  (w_dropped)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_OFF;
            r_gap   <= '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (ctrl_en) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_brk) begin
                        r_state <= ST_BREAK;
                        r_gap   <= c_gap_load;
                    end else if (!ctrl_en) begin
                        r_state <= ST_OFF;
                    end else if (fifo_count >= CW'(FIFO_DEPTH - 1)) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_brk) begin
                        r_state <= ST_BREAK;
                        r_gap   <= c_gap_load;
                    end else if (!ctrl_en) begin
                        r_state <= ST_OFF;
                    end else if (fifo_count <= CW'(FIFO_DEPTH / 2)) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_BREAK: begin
                    if (r_gap == '0) begin
                        r_state <= ctrl_en ? ST_RUN : ST_OFF;
                    end else begin
                        r_gap <= r_gap - 16'd1;
                    end
                end
                default: r_state <= ST_OFF;
            endcase
        end
    end

    assign rx_en = (r_state == ST_RUN);

    // Set events take priority over a coincident clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun   <= 1'b0;
            r_break_det <= 1'b0;
        end else begin
            if (w_dropped)       r_overrun <= 1'b1;
            else if (clr_status) r_overrun <= 1'b0;
            if (w_brk)           r_break_det <= 1'b1;
            else if (clr_status) r_break_det <= 1'b0;
        end
    end

    assign w_idle_clr  = w_pushed | w_popped | ~rd_valid;
    assign w_idle_next = r_idle + 16'd1;

    // Saturation keeps the timer parked past the trip point, so one pulse per idle period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idle     <= '0;
            r_idle_irq <= 1'b0;
        end else if (w_idle_clr) begin
            r_idle     <= '0;
            r_idle_irq <= 1'b0;
        end else if (r_idle != 16'hFFFF) begin
            r_idle     <= w_idle_next;
            r_idle_irq <= (w_idle_next == c_idle_trip);
        end else begin
            r_idle_irq <= 1'b0;
        end
    end

    assign overrun   = r_overrun;
    assign break_det = r_break_det;
    assign idle_irq  = r_idle_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_ctrl : directed vector table plus hand sequences for       |
// | BREAK gap, idle timeout and asynchronous reset.                       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_uart_rx_ctrl;

    localparam int FIFO_DEPTH   = 4;
    localparam int IDLE_TIMEOUT = 16;
    localparam int BREAK_GAP    = 8;
    localparam int CW           = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ctrl_en;
    logic          clr_status;
    logic          rx_valid;
    logic          rx_break;
    logic [7:0]    rx_data;
    logic          rx_en;
    logic          rd_req;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic [CW-1:0] fifo_count;
    logic          overrun;
    logic          break_det;
    logic          idle_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .BREAK_GAP    (BREAK_GAP),
        .CW           (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ctrl_en    (ctrl_en),
        .clr_status (clr_status),
        .rx_valid   (rx_valid),
        .rx_break   (rx_break),
        .rx_data    (rx_data),
        .rx_en      (rx_en),
        .rd_req     (rd_req),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .break_det  (break_det),
        .idle_irq   (idle_irq)
    );

    typedef struct packed {
        logic       ce;
        logic       clr;
        logic       rv;
        logic       rb;
        logic [7:0] d;
        logic       rr;
        logic       en;
        logic       rdv;
        logic [7:0] rdd;
        logic [2:0] cnt;
        logic       ov;
        logic       bd;
        logic       irq;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic ce, clr, rv, rb, input logic [7:0] d,
                                input logic rr, en, rdv, input logic [7:0] rdd,
                                input logic [2:0] cnt, input logic ov, bd, irq);
        vec_t v;
        v.ce = ce;  v.clr = clr; v.rv = rv;   v.rb = rb;   v.d = d;   v.rr = rr;
        v.en = en;  v.rdv = rdv; v.rdd = rdd; v.cnt = cnt; v.ov = ov; v.bd = bd;
        v.irq = irq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        clr_status = 1'b0;
        rx_valid   = 1'b0;
        rx_break   = 1'b0;
        rx_data    = 8'h00;
        rd_req     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rx_en"},      32'(rx_en),      32'd0);
        check({tag, " rd_valid"},   32'(rd_valid),   32'd0);
        check({tag, " rd_data"},    32'(rd_data),    32'd0);
        check({tag, " fifo_count"}, 32'(fifo_count), 32'd0);
        check({tag, " overrun"},    32'(overrun),    32'd0);
        check({tag, " break_det"},  32'(break_det),  32'd0);
        check({tag, " idle_irq"},   32'(idle_irq),   32'd0);
    endtask

    initial begin
        bit done;
        resetn  = 1'b0;
        ctrl_en = 1'b0;
        quiet();
        tick();
        tick();
        check_all_zero("reset");
        resetn = 1'b1;

        // ce clr rv rb data rr | en rdv rdd cnt ov bd irq
        vq.push_back(mk(1, 0, 0, 0, 8'h00, 0,  1, 0, 8'h00, 3'd0, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 8'h55, 0,  1, 1, 8'h55, 3'd1, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 8'h00, 1,  1, 0, 8'h00, 3'd0, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 8'h01, 0,  1, 1, 8'h01, 3'd1, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 8'h02, 0,  1, 1, 8'h01, 3'd2, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 8'h03, 0,  1, 1, 8'h01, 3'd3, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 8'h00, 0,  0, 1, 8'h01, 3'd3, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 8'h04, 0,  0, 1, 8'h01, 3'd4, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 8'h05, 0,  0, 1, 8'h01, 3'd4, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 8'h00, 1,  0, 1, 8'h02, 3'd3, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 8'h00, 1,  0, 1, 8'h03, 3'd2, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 8'h00, 1,  1, 1, 8'h04, 3'd1, 1, 0, 0));
        vq.push_back(mk(1, 1, 0, 0, 8'h00, 0,  1, 1, 8'h04, 3'd1, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 8'h06, 0,  1, 1, 8'h04, 3'd2, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 8'h07, 0,  1, 1, 8'h04, 3'd3, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 8'h08, 0,  0, 1, 8'h04, 3'd4, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 8'h0A, 1,  0, 1, 8'h06, 3'd4, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 8'h00, 1,  0, 1, 8'h07, 3'd3, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 8'h00, 1,  0, 1, 8'h08, 3'd2, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 8'h00, 1,  1, 1, 8'h0A, 3'd1, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 8'h00, 1,  1, 0, 8'h00, 3'd0, 0, 0, 0));

        foreach (vq[i]) begin
            ctrl_en    = vq[i].ce;
            clr_status = vq[i].clr;
            rx_valid   = vq[i].rv;
            rx_break   = vq[i].rb;
            rx_data    = vq[i].d;
            rd_req     = vq[i].rr;
            tick();
            check($sformatf("vec%0d rx_en", i),      32'(rx_en),      32'(vq[i].en));
            check($sformatf("vec%0d rd_valid", i),   32'(rd_valid),   32'(vq[i].rdv));
            check($sformatf("vec%0d rd_data", i),    32'(rd_data),    32'(vq[i].rdd));
            check($sformatf("vec%0d fifo_count", i), 32'(fifo_count), 32'(vq[i].cnt));
            check($sformatf("vec%0d overrun", i),    32'(overrun),    32'(vq[i].ov));
            check($sformatf("vec%0d break_det", i),  32'(break_det),  32'(vq[i].bd));
            check($sformatf("vec%0d idle_irq", i),   32'(idle_irq),   32'(vq[i].irq));
        end
        quiet();

        // BREAK: no push, rx_en low for exactly BREAK_GAP cycles.
        rx_valid = 1'b1;
        rx_break = 1'b1;
        rx_data  = 8'h00;
        tick();
        quiet();
        check("brk break_det", 32'(break_det),  32'd1);
        check("brk no push",   32'(fifo_count), 32'd0);
        check("brk rx_en c0",  32'(rx_en),      32'd0);
        for (int k = 1; k < BREAK_GAP; k++) begin
            tick();
            check($sformatf("brk rx_en c%0d", k), 32'(rx_en), 32'd0);
        end
        tick();
        check("brk rx_en back", 32'(rx_en), 32'd1);

        clr_status = 1'b1;
        rx_valid   = 1'b1;
        rx_break   = 1'b1;
        tick();
        quiet();
        check("brk set beats clr", 32'(break_det), 32'd1);
        clr_status = 1'b1;
        tick();
        quiet();
        check("brk clr", 32'(break_det), 32'd0);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (rx_en) done = 1'b1;
        end
        check("brk2 return timeout", 32'(done), 32'd1);

        // Idle timeout: a single pulse IDLE_TIMEOUT cycles after the last push.
        rx_valid = 1'b1;
        rx_data  = 8'h7E;
        tick();
        quiet();
        check("idle push count", 32'(fifo_count), 32'd1);
        check("idle push data",  32'(rd_data),    32'h7E);
        for (int k = 1; k <= 30; k++) begin
            tick();
            check($sformatf("idle_irq c%0d", k), 32'(idle_irq), 32'(k == IDLE_TIMEOUT));
        end
        rd_req = 1'b1;
        tick();
        quiet();
        check("idle pop count", 32'(fifo_count), 32'd0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            check($sformatf("idle empty c%0d", k), 32'(idle_irq), 32'd0);
        end

        // OFF still accepts an in-flight byte.
        ctrl_en = 1'b0;
        tick();
        check("off rx_en", 32'(rx_en), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        tick();
        quiet();
        check("off push count", 32'(fifo_count), 32'd1);
        check("off push data",  32'(rd_data),    32'h33);
        check("off rx_en hold", 32'(rx_en),      32'd0);

        // Asynchronous reset in the middle of a BREAK.
        ctrl_en = 1'b1;
        tick();
        check("rst pre rx_en", 32'(rx_en), 32'd1);
        rx_valid = 1'b1;
        rx_break = 1'b1;
        rx_data  = 8'h00;
        tick();
        quiet();
        check("rst pre break_det", 32'(break_det), 32'd1);
        #3;
        resetn = 1'b0;
        #1;
        check_all_zero("async reset");
        ctrl_en = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        check_all_zero("post reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
